// File: rtl/dft_bin_scheduler.sv
// Buffers one multichannel frame and replays it once per bin through a shared serial
// single-bin DFT core, then hands each bin's re/im result out on a ready/valid port.
module dft_bin_scheduler #(
  parameter int unsigned X_WIDTH      = 16,
  parameter int unsigned S_WIDTH      = 32,
  parameter int unsigned FRAME_LENGTH = 8,
  parameter int unsigned BINS         = 4,
  parameter int unsigned CHANELS      = 2,
  localparam int unsigned NW          = $clog2(FRAME_LENGTH),
  localparam int unsigned BW          = (BINS > 1) ? $clog2(BINS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANELS*X_WIDTH-1:0]   s_x,
  output logic                         core_valid,
  output logic [CHANELS*X_WIDTH-1:0]   core_x,
  output logic [NW-1:0]                tw_idx,
  input  logic [NW-1:0]                core_counter,
  input  logic                         core_valid_o,
  input  logic [CHANELS*S_WIDTH-1:0]   core_re,
  input  logic [CHANELS*S_WIDTH-1:0]   core_im,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [BW-1:0]                res_bin,
  output logic [CHANELS*S_WIDTH-1:0]   res_re,
  output logic [CHANELS*S_WIDTH-1:0]   res_im,
  output logic                         sync_err
);

  localparam logic [1:0] StLoad = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  localparam logic [NW-1:0] NLast = NW'(FRAME_LENGTH - 1);
  localparam logic [BW-1:0] KLast = BW'(BINS - 1);
  localparam logic [NW:0]   NFull = (NW + 1)'(FRAME_LENGTH);

  logic [1:0]                   state_q, state_d;
  logic [NW-1:0]                n_q, n_d;
  logic [NW-1:0]                idx_q, idx_d;
  logic [BW-1:0]                k_q, k_d;
  logic                         sync_err_q, sync_err_d;
  logic [BW-1:0]                res_bin_q, res_bin_d;
  logic [CHANELS*S_WIDTH-1:0]   res_re_q, res_re_d;
  logic [CHANELS*S_WIDTH-1:0]   res_im_q, res_im_d;
  logic [NW:0]                  idx_sum;

  logic [CHANELS*X_WIDTH-1:0]   frame_q [FRAME_LENGTH];

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    idx_d      = idx_q;
    sync_err_d = sync_err_q;
    res_bin_d  = res_bin_q;
    res_re_d   = res_re_q;
    res_im_d   = res_im_q;
    // Running twiddle index: idx tracks (k*n) mod N by repeated add-and-wrap.
    idx_sum    = {1'b0, idx_q} + (NW + 1)'(k_q);

    unique case (state_q)
      StLoad: begin
        if (s_valid) begin
          if (n_q == NLast) begin
            n_d     = '0;
            k_d     = '0;
            idx_d   = '0;
            state_d = StRun;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (core_counter != n_q) sync_err_d = 1'b1;
        if (n_q == NLast) begin
          n_d     = '0;
          idx_d   = '0;
          state_d = StWait;
        end else begin
          n_d   = n_q + 1'b1;
          idx_d = (idx_sum >= NFull) ? NW'(idx_sum - NFull) : NW'(idx_sum);
        end
      end
      StWait: begin
        if (core_valid_o) begin
          res_re_d  = core_re;
          res_im_d  = core_im;
          res_bin_d = k_q;
          state_d   = StOut;
        end
      end
      StOut: begin
        if (res_ready) begin
          if (k_q == KLast) begin
            state_d = StLoad;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = StRun;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      n_q        <= '0;
      k_q        <= '0;
      idx_q      <= '0;
      sync_err_q <= 1'b0;
      res_bin_q  <= '0;
      res_re_q   <= '0;
      res_im_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      sync_err_q <= sync_err_d;
      res_bin_q  <= res_bin_d;
      res_re_q   <= res_re_d;
      res_im_q   <= res_im_d;
    end
  end

  // Frame storage needs no reset; it is fully rewritten before every replay.
  always_ff @(posedge clk) begin
    if ((state_q == StLoad) && s_valid) frame_q[n_q] <= s_x;
  end

  assign s_ready    = (state_q == StLoad);
  assign core_valid = (state_q == StRun);
  assign res_valid  = (state_q == StOut);
  assign core_x     = frame_q[n_q];
  assign tw_idx     = idx_q;
  assign res_bin    = res_bin_q;
  assign res_re     = res_re_q;
  assign res_im     = res_im_q;
  assign sync_err   = sync_err_q;

endmodule

// File: doc/dft_bin_scheduler.md
Name: dft_bin_scheduler

Overview:
- Sequencer that shares one serial single-bin DFT accumulator core (CHANELS lanes, one twiddle per sample) across BINS frequency bins.
- Buffers one input frame of FRAME_LENGTH multichannel samples, then replays it once per bin k = 0..BINS-1.
- For each replayed sample it drives the core's sample, valid and twiddle index. It collects each bin's re/im result and presents it on a ready/valid result port tagged with the bin number.

Parameters:
- X_WIDTH, 16, sample width per channel.
- S_WIDTH, 32, core accumulator/result width per channel.
- FRAME_LENGTH, 8, samples per frame N; must be >= 2.
- BINS, 4, number of bins computed per frame; 1 <= BINS <= FRAME_LENGTH.
- CHANELS, 2, parallel channels.
- Derived: NW = $clog2(FRAME_LENGTH), BW = max(1, $clog2(BINS)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  scheduler accepts a sample.
- s_x  in  CHANELS*X_WIDTH  input sample, lane i at bits [i*X_WIDTH +: X_WIDTH].
- core_valid  out  1  drives core valid_i.
- core_x  out  CHANELS*X_WIDTH  drives core x.
- tw_idx  out  NW  twiddle ROM index, (k*n) mod FRAME_LENGTH.
- core_counter  in  NW  core's internal sample counter.
- core_valid_o  in  1  core result valid.
- core_re, core_im  in  CHANELS*S_WIDTH each  core results.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_bin  out  BW  bin k of the presented result.
- res_re, res_im  out  CHANELS*S_WIDTH each  captured results.
- sync_err  out  1  sticky core/scheduler counter mismatch.

Behaviour:
- States: LOAD, RUN, WAIT, OUT. Counters: n (NW bits), k (BW bits), idx (NW bits).
- Reset (rst=1 at a clock edge):
  - state=LOAD; n=k=idx=0.
  - s_ready=1 on the first cycle after reset.
  - core_valid=0, res_valid=0, sync_err=0.
  - res_re, res_im, res_bin = 0.
  - Buffer contents are don't-care.
  - Reset mid-operation abandons the frame and any pending result. The core is not reset by this block; the system resets both together.
- LOAD:
  - s_ready=1.
  - On s_valid, write s_x to buffer[n] and increment n.
  - When n = FRAME_LENGTH-1 and s_valid: n=0, k=0, idx=0, go RUN.
- RUN:
  - s_ready=0. core_valid=1 every cycle. core_x = buffer[n]. tw_idx = idx.
  - Each cycle: n increments. idx = idx+k, and if the sum >= FRAME_LENGTH subtract FRAME_LENGTH (no multiplier).
  - If core_counter != n while core_valid=1, set sync_err; it stays set until rst.
  - After n = FRAME_LENGTH-1 is issued: n=0, idx=0, go WAIT.
  - Exactly FRAME_LENGTH consecutive core_valid pulses are issued per bin.
- WAIT:
  - core_valid=0.
  - On the first cycle with core_valid_o=1, register core_re, core_im into res_re, res_im, set res_bin=k, then go OUT.
  - Minimum latency is 1 cycle after the last RUN cycle.
- OUT:
  - res_valid=1; data is held stable until the handshake.
  - On res_ready: res_valid=0 next cycle.
    - If k = BINS-1, go LOAD.
    - Else k=k+1, go RUN.
  - res_ready while res_valid=0 is ignored.
- Throughput: one frame per BINS*(FRAME_LENGTH+2)+FRAME_LENGTH cycles with zero backpressure. There is no load/compute overlap.
- Arithmetic: all index math is unsigned modulo FRAME_LENGTH. Data passes through unmodified; the scheduler performs no data arithmetic.
- s_valid while s_ready=0 is ignored; the sample is not consumed.

Test Plan:
- Load/run order: N=8, BINS=4, lane0 samples 1..8 with s_valid held high. Required: s_ready drops after the 8th sample. k=0 replays core_x=1..8 with tw_idx all 0. k=1 gives tw_idx 0,1,2,3,4,5,6,7.
- Twiddle wrap: for the same frame, k=3 gives tw_idx 0,3,6,1,4,7,2,5, and k=2 gives 0,2,4,6,0,2,4,6.
- Result path with a behavioural core model (sums x*1 on re, x*2 on im): res_bin 0..3 in order, each with res_re=36 and res_im=72 on lane0. Exactly 4 results per frame, then s_ready=1.
- Backpressure: hold res_ready=0 for 10 cycles on bin 1. Required: res_valid and data stay stable, core_valid stays 0, and the bin 2 replay starts the cycle after res_ready=1.
- Reset mid-run: assert rst during k=2, n=5. Required: the next cycle shows s_ready=1, core_valid=0, res_valid=0, sync_err=0. A fresh frame then produces bins 0..3 correctly.
- Sync error: force the core model's counter to lag by one during RUN. Required: sync_err=1 within the first RUN cycle and it stays 1 until rst.
